// File: rtl/excp_pkg.sv
// rtl/excp_pkg.sv - shared types and constants for the exception PC sequencer
package excp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_MREQ,
        ST_MWAIT,
        ST_LOADPC,
        ST_ACK
    } excp_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_OPC  = 2'd1,
        CAUSE_OVF  = 2'd2,
        CAUSE_DIV0 = 2'd3
    } excp_cause_t;

    typedef enum logic [2:0] {
        PCSRC_A    = 3'd0,
        PCSRC_B    = 3'd1,
        PCSRC_ALU  = 3'd2,
        PCSRC_JUMP = 3'd3,
        PCSRC_JR   = 3'd4,
        PCSRC_EXCP = 3'd5
    } pcsrc_t;

    localparam int unsigned VEC_OPC_DEF  = 253;
    localparam int unsigned VEC_OVF_DEF  = 254;
    localparam int unsigned VEC_DIV0_DEF = 255;

    // Invalid opcode wins over overflow, overflow over divide-by-zero.
    function automatic excp_cause_t prio_cause(input logic opc, input logic ovf, input logic div0);
        if (opc)
            return CAUSE_OPC;
        else if (ovf)
            return CAUSE_OVF;
        else if (div0)
            return CAUSE_DIV0;
        else
            return CAUSE_NONE;
    endfunction

    function automatic logic [31:0] vec_addr(input excp_cause_t c, input int unsigned v_opc,
                                             input int unsigned v_ovf, input int unsigned v_div0);
        case (c)
            CAUSE_OPC:  return 32'(v_opc);
            CAUSE_OVF:  return 32'(v_ovf);
            CAUSE_DIV0: return 32'(v_div0);
            default:    return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/excp_lat_counter.sv
// rtl/excp_lat_counter.sv - memory latency down-counter with load and zero flag
module excp_lat_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/excp_pc_sequencer.sv
// rtl/excp_pc_sequencer.sv - exception entry sequencer: EPC save, vector fetch, PC load
// Optional EXCP_CAUSE_REG_EN: exports the latched cause and blocks back-to-back entry from ACK.
module excp_pc_sequencer
    import excp_pkg::*;
#(
    parameter int unsigned MEM_LAT  = 2,
    parameter int unsigned VEC_OPC  = VEC_OPC_DEF,
    parameter int unsigned VEC_OVF  = VEC_OVF_DEF,
    parameter int unsigned VEC_DIV0 = VEC_DIV0_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        excp_req,
    input  logic        flag_opc,
    input  logic        flag_ovf,
    input  logic        flag_div0,
    input  logic [31:0] pc_cur,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [31:0] epc_d,
    output logic        epc_wr,
    output logic [31:0] excp_code,
    output logic [2:0]  pc_src,
    output logic        pc_wr,
    output logic        excp_ack,
    output logic        busy
`ifdef EXCP_CAUSE_REG_EN
    ,
    output logic [1:0]  cause
`endif
);

    localparam int unsigned CW = $clog2(MEM_LAT) + 1;

    excp_state_t state;
    excp_cause_t cause_q;
    logic        any_flag;
    logic        start;
    logic        cnt_zero;

    assign any_flag = flag_opc | flag_ovf | flag_div0;

    // A fresh request is not taken while the spurious-request ack is still visible.
`ifdef EXCP_CAUSE_REG_EN
    assign start = excp_req && any_flag && (state == ST_IDLE) && !excp_ack;
`else
    assign start = excp_req && any_flag &&
                   (((state == ST_IDLE) && !excp_ack) || (state == ST_ACK));
`endif

    excp_lat_counter #(.W(CW)) u_lat (
        .clk      (clk),
        .rst_n    (reset_n),
        .load     (state == ST_MREQ),
        .load_val (CW'(MEM_LAT - 1)),
        .dec      (state == ST_MWAIT),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            epc_d     <= '0;
            epc_wr    <= 1'b0;
            excp_code <= '0;
            pc_src    <= PCSRC_A;
            pc_wr     <= 1'b0;
            excp_ack  <= 1'b0;
            busy      <= 1'b0;
`ifdef EXCP_CAUSE_REG_EN
            cause     <= CAUSE_NONE;
`endif
        end else begin
            mem_rd   <= 1'b0;
            epc_wr   <= 1'b0;
            pc_wr    <= 1'b0;
            excp_ack <= 1'b0;
            pc_src   <= PCSRC_A;
            if (start) begin
                state   <= ST_SAVE;
                cause_q <= prio_cause(flag_opc, flag_ovf, flag_div0);
                epc_d   <= pc_cur - 32'd4;
                epc_wr  <= 1'b1;
                busy    <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        busy <= 1'b0;
                        if (excp_req && !excp_ack)
                            excp_ack <= 1'b1;
                    end
                    ST_SAVE: begin
                        state    <= ST_MREQ;
                        mem_addr <= vec_addr(cause_q, VEC_OPC, VEC_OVF, VEC_DIV0);
                        mem_rd   <= 1'b1;
`ifdef EXCP_CAUSE_REG_EN
                        cause    <= cause_q;
`endif
                    end
                    ST_MREQ: begin
                        state <= ST_MWAIT;
                    end
                    ST_MWAIT: begin
                        if (cnt_zero) begin
                            state     <= ST_LOADPC;
                            excp_code <= {24'b0, mem_rdata};
                            mem_addr  <= '0;
                            pc_src    <= PCSRC_EXCP;
                            pc_wr     <= 1'b1;
                        end
                    end
                    ST_LOADPC: begin
                        state    <= ST_ACK;
                        excp_ack <= 1'b1;
                    end
                    ST_ACK: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_excp_pc_sequencer.sv
// tb/tb_excp_pc_sequencer.sv - randomized self-checking bench for excp_pc_sequencer
module tb_excp_pc_sequencer;

    localparam int ML = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        excp_req;
    logic        flag_opc, flag_ovf, flag_div0;
    logic [31:0] pc_cur;
    logic [7:0]  mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] epc_d;
    logic        epc_wr;
    logic [31:0] excp_code;
    logic [2:0]  pc_src;
    logic        pc_wr;
    logic        excp_ack;
    logic        busy;
`ifdef EXCP_CAUSE_REG_EN
    logic [1:0]  cause;
`endif

    int checks = 0;
    int errors = 0;

    excp_pc_sequencer #(.MEM_LAT(ML)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .excp_req  (excp_req),
        .flag_opc  (flag_opc),
        .flag_ovf  (flag_ovf),
        .flag_div0 (flag_div0),
        .pc_cur    (pc_cur),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .epc_d     (epc_d),
        .epc_wr    (epc_wr),
        .excp_code (excp_code),
        .pc_src    (pc_src),
        .pc_wr     (pc_wr),
        .excp_ack  (excp_ack),
        .busy      (busy)
`ifdef EXCP_CAUSE_REG_EN
        ,
        .cause     (cause)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_strobes(input string tag);
        chk({tag, " epc_wr"}, 32'(epc_wr), 32'd0);
        chk({tag, " pc_wr"}, 32'(pc_wr), 32'd0);
        chk({tag, " mem_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    // fl[0]=opc fl[1]=ovf fl[2]=div0; cycle k counts from the cycle after excp_req is sampled
    task automatic run_seq(input logic [2:0] fl, input logic [31:0] pc, input logic [7:0] rd);
        logic [31:0] exp_vec;
        logic [1:0]  exp_cause;
        int          t_ack;
        exp_vec   = fl[0] ? 32'd253 : (fl[1] ? 32'd254 : 32'd255);
        exp_cause = fl[0] ? 2'd1 : (fl[1] ? 2'd2 : 2'd3);
        t_ack     = ML + 4;
        @(negedge clk);
        excp_req  = 1'b1;
        {flag_div0, flag_ovf, flag_opc} = fl;
        pc_cur    = pc;
        mem_rdata = 8'($urandom);
        for (int k = 1; k <= ML + 5; k++) begin
            @(negedge clk);
            chk("epc_wr", 32'(epc_wr), 32'(k == 1));
            chk("mem_rd", 32'(mem_rd), 32'(k == 2));
            chk("pc_wr", 32'(pc_wr), 32'(k == t_ack - 1));
            chk("pc_src", 32'(pc_src), (k == t_ack - 1) ? 32'd5 : 32'd0);
            chk("excp_ack", 32'(excp_ack), 32'(k == t_ack));
            chk("busy", 32'(busy), 32'(k <= t_ack));
            if (k == 1)
                chk("epc_d", epc_d, pc - 32'd4);
            if (k >= 2 && k <= ML + 2)
                chk("mem_addr", mem_addr, exp_vec);
            if (k >= t_ack - 1)
                chk("excp_code", excp_code, {24'b0, rd});
`ifdef EXCP_CAUSE_REG_EN
            if (k >= 2)
                chk("cause", 32'(cause), 32'(exp_cause));
`else
            if (k == 2 && exp_cause == 2'd0)
                chk("cause model", 32'(exp_cause), 32'd1);
`endif
            if (k == 1) begin
                excp_req = 1'b0;
                {flag_div0, flag_ovf, flag_opc} = 3'($urandom);
                pc_cur = $urandom;
            end
            mem_rdata = (k == ML + 2) ? rd : 8'($urandom);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        excp_req  = 1'b0;
        {flag_opc, flag_ovf, flag_div0} = 3'b000;
        pc_cur    = 32'h0;
        mem_rdata = 8'h0;

        repeat (2) @(negedge clk);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst epc_d", epc_d, 32'd0);
        chk("rst excp_code", excp_code, 32'd0);
        chk("rst pc_src", 32'(pc_src), 32'd0);
        chk("rst excp_ack", 32'(excp_ack), 32'd0);
        chk_idle_strobes("rst");
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_idle_strobes("post-rst");
            chk("post-rst ack", 32'(excp_ack), 32'd0);
        end

        run_seq(3'b010, 32'h40, 8'h80);
        run_seq(3'b101, 32'h1234, 8'h5A);
        run_seq(3'b100, 32'h0, 8'hFF);
        run_seq(3'b001, 32'hFFFF_FFFF, 8'h00);

        for (int i = 0; i < 20; i++)
            run_seq(3'($urandom_range(1, 7)), $urandom, 8'($urandom));

        // spurious request: ack one cycle later, nothing written
        @(negedge clk);
        excp_req = 1'b1;
        {flag_opc, flag_ovf, flag_div0} = 3'b000;
        @(negedge clk);
        chk("spur ack", 32'(excp_ack), 32'd1);
        chk_idle_strobes("spur");
        excp_req = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            chk("spur ack2", 32'(excp_ack), 32'd0);
            chk_idle_strobes("spur");
        end

        // reset mid-MWAIT aborts the sequence without later writes
        @(negedge clk);
        excp_req = 1'b1;
        flag_ovf = 1'b1;
        pc_cur   = 32'h100;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                excp_req = 1'b0;
                flag_ovf = 1'b0;
            end
        end
        chk("abort in mwait", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort mem_addr", mem_addr, 32'd0);
        chk("abort pc_src", 32'(pc_src), 32'd0);
        chk_idle_strobes("abort");
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort ack", 32'(excp_ack), 32'd0);
            chk_idle_strobes("abort-rel");
        end

        run_seq(3'b110, 32'h8000_0004, 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
